// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one hex2bcd converter between three requesters.
// Each grant latches an operand, drives the converter, and returns a registered BCD result with ack.
module bcd_conv_arbiter #(
    parameter int START_LEN = 4,
    parameter int TMO       = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [6:0] val0,
    input  logic [6:0] val1,
    input  logic [6:0] val2,
    output logic [2:0] ack,
    output logic [3:0] bcd_hi,
    output logic [3:0] bcd_lo,
    output logic       err,
    output logic       busy,
    output logic       conv_start,
    output logic [6:0] conv_din,
    input  logic       conv_done,
    input  logic [3:0] conv_bcd_h,
    input  logic [3:0] conv_bcd_l
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [7:0] START_LAST = 8'(START_LEN - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TMO - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic [1:0] win_idx;
    logic       win_valid;
    logic [6:0] win_val;
    logic [6:0] operand;
    logic [7:0] cnt;
    logic       err_flag;
    logic       out_of_range;

    assign out_of_range = operand > 7'd99;

    // Winner is the first requesting index starting from ptr and wrapping mod 3.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_valid = |req;
        win_idx   = ptr;
        case (ptr)
            2'd1:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        win_val = val0;
        case (win_idx)
            2'd1:    win_val = val1;
            2'd2:    win_val = val2;
            default: win_val = val0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_valid) state_nxt = START;
            START: begin
                if (out_of_range)            state_nxt = DONE;
                else if (cnt == START_LAST)  state_nxt = WAIT;
            end
            WAIT: begin
                if (conv_done)               state_nxt = DONE;
                else if (cnt == TMO_LAST)    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand/grant capture, shared start/timeout counter, result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= 2'd0;
            grant    <= 2'd0;
            operand  <= 7'd0;
            cnt      <= 8'd0;
            err_flag <= 1'b0;
            bcd_hi   <= 4'd0;
            bcd_lo   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        operand  <= win_val;
                        grant    <= win_idx;
                        cnt      <= 8'd0;
                        err_flag <= 1'b0;
                    end
                end
                START: begin
                    if (out_of_range) begin
                        bcd_hi   <= 4'hF;
                        bcd_lo   <= 4'hF;
                        err_flag <= 1'b1;
                        cnt      <= 8'd0;
                    end else if (cnt == START_LAST) begin
                        cnt <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (conv_done) begin
                        bcd_hi <= conv_bcd_h;
                        bcd_lo <= conv_bcd_l;
                    end else if (cnt == TMO_LAST) begin
                        bcd_hi   <= 4'hF;
                        bcd_lo   <= 4'hF;
                        err_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    ptr      <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                    cnt      <= 8'd0;
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        conv_start = (state == START) && !out_of_range;
        conv_din   = (state == START || state == WAIT) ? operand : 7'd0;
        ack        = (state == DONE) ? (3'b001 << grant) : 3'b000;
        err        = (state == DONE) && err_flag;
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: vector table, hand-written corner sequences,
// and randomized multi-requester traffic against a round-robin/arithmetic reference model.
module tb_bcd_conv_arbiter;

    localparam int START_LEN = 4;
    localparam int TMO       = 31;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [6:0] vals [3];
    logic [2:0] ack;
    logic [3:0] bcd_hi, bcd_lo;
    logic       err, busy, conv_start;
    logic [6:0] conv_din;
    logic       conv_done;
    logic [3:0] conv_bcd_h, conv_bcd_l;

    int checks   = 0;
    int failures = 0;

    // Converter model state
    int         conv_delay = 10;
    int         cd         = 0;
    logic       pend       = 1'b0;
    logic       prev_start = 1'b0;
    int         start_cnt  = 0;
    int         din_bad    = 0;
    logic [6:0] m_val      = 7'd0;
    int         mon_bad    = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.START_LEN(START_LEN), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .val0       (vals[0]),
        .val1       (vals[1]),
        .val2       (vals[2]),
        .ack        (ack),
        .bcd_hi     (bcd_hi),
        .bcd_lo     (bcd_lo),
        .err        (err),
        .busy       (busy),
        .conv_start (conv_start),
        .conv_din   (conv_din),
        .conv_done  (conv_done),
        .conv_bcd_h (conv_bcd_h),
        .conv_bcd_l (conv_bcd_l)
    );

    // Shared converter: pulses done conv_delay cycles after the first start cycle.
    initial begin
        conv_done  = 1'b0;
        conv_bcd_h = 4'hC;
        conv_bcd_l = 4'hC;
    end

    always @(negedge clk) begin
        conv_done  = 1'b0;
        conv_bcd_h = 4'hC;
        conv_bcd_l = 4'hC;
        if (rst !== 1'b1) begin
            pend       = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (pend) begin
                cd = cd - 1;
                if (cd == 0) begin
                    conv_done  = 1'b1;
                    conv_bcd_h = 4'(m_val / 10);
                    conv_bcd_l = 4'(m_val % 10);
                    pend       = 1'b0;
                end
            end
            if (conv_start) begin
                start_cnt = start_cnt + 1;
                if (!prev_start) begin
                    pend  = 1'b1;
                    cd    = conv_delay;
                    m_val = conv_din;
                end else if (conv_din != m_val) begin
                    din_bad = din_bad + 1;
                end
            end
            prev_start = conv_start;
        end
    end

    // Protocol monitor: ack one-hot, err only with ack, ack only while busy.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (!$onehot0(ack))          mon_bad = mon_bad + 1;
            if (err && ack == 3'b000)    mon_bad = mon_bad + 1;
            if (ack != 3'b000 && !busy)  mon_bad = mon_bad + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Waits (bounded) for an ack; latency counts negedges after the cycle inputs were applied.
    task automatic wait_ack(input string name, input int limit, output int a, output int e,
                            output int h, output int l, output int lat);
        int got;
        got = 0; a = 0; e = 0; h = 0; l = 0; lat = 0;
        for (int i = 1; i <= limit && got == 0; i++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                got = 1;
                a   = int'(ack);
                e   = int'(err);
                h   = int'(bcd_hi);
                l   = int'(bcd_lo);
                lat = i;
            end
        end
        check({name, "_ack_seen"}, got, 1);
    endtask

    function automatic void ref_result(input int v, input int dly, output int h, output int l,
                                       output int e);
        if (v > 99) begin
            h = 15; l = 15; e = 1;
        end else if (dly >= START_LEN && dly <= START_LEN + TMO - 1) begin
            h = v / 10; l = v % 10; e = 0;
        end else begin
            h = 15; l = 15; e = 1;
        end
    endfunction

    typedef struct {
        int idx;
        int val;
        int dly;
        int exp_ack;
        int exp_hi;
        int exp_lo;
        int exp_err;
        int exp_lat;
        int exp_starts;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int a, e, h, l, lat;
        int rr_ack [4];
        int rr_hi  [4];
        int rr_lo  [4];
        int pend_m, ptr, exp_idx, dly, rh, rl, re;

        //          idx val  dly  ack hi  lo  err lat starts
        vecs[0] = '{0,  57,  10,  1,  5,  7,  0,  12, 4};
        vecs[1] = '{1,  120, 10,  2,  15, 15, 1,  2,  0};
        vecs[2] = '{2,  0,   4,   4,  0,  0,  0,  6,  4};
        vecs[3] = '{0,  99,  34,  1,  9,  9,  0,  36, 4};
        vecs[4] = '{1,  42,  35,  2,  15, 15, 1,  36, 4};
        vecs[5] = '{2,  10,  3,   4,  15, 15, 1,  36, 4};
        vecs[6] = '{0,  100, 10,  1,  15, 15, 1,  2,  0};
        vecs[7] = '{1,  127, 10,  2,  15, 15, 1,  2,  0};
        vecs[8] = '{2,  9,   20,  4,  0,  9,  0,  22, 4};
        rr_ack = '{1, 2, 4, 1};
        rr_hi  = '{1, 3, 9, 1};
        rr_lo  = '{2, 4, 9, 2};

        rst  = 1'b0;
        req  = 3'b000;
        vals = '{7'd0, 7'd0, 7'd0};
        repeat (2) @(negedge clk);
        check("rst_ack",        int'(ack),        0);
        check("rst_err",        int'(err),        0);
        check("rst_busy",       int'(busy),       0);
        check("rst_conv_start", int'(conv_start), 0);
        check("rst_conv_din",   int'(conv_din),   0);
        check("rst_bcd_hi",     int'(bcd_hi),     0);
        check("rst_bcd_lo",     int'(bcd_lo),     0);
        rst = 1'b1;
        @(negedge clk);

        // Single-requester vectors: latency, range and timeout boundaries.
        for (int i = 0; i < 9; i++) begin
            start_cnt          = 0;
            din_bad            = 0;
            vals[vecs[i].idx]  = 7'(vecs[i].val);
            req                = 3'(1 << vecs[i].idx);
            conv_delay         = vecs[i].dly;
            wait_ack($sformatf("row%0d", i), 100, a, e, h, l, lat);
            req = 3'b000;
            check($sformatf("row%0d_ack", i),    a,         vecs[i].exp_ack);
            check($sformatf("row%0d_hi", i),     h,         vecs[i].exp_hi);
            check($sformatf("row%0d_lo", i),     l,         vecs[i].exp_lo);
            check($sformatf("row%0d_err", i),    e,         vecs[i].exp_err);
            check($sformatf("row%0d_lat", i),    lat,       vecs[i].exp_lat);
            check($sformatf("row%0d_starts", i), start_cnt, vecs[i].exp_starts);
            if (vecs[i].exp_starts > 0) begin
                check($sformatf("row%0d_din", i),     int'(m_val), vecs[i].val);
                check($sformatf("row%0d_din_hold", i), din_bad,    0);
            end
            @(negedge clk);
            check($sformatf("row%0d_busy_after", i), int'(busy),   0);
            check($sformatf("row%0d_hi_hold", i),    int'(bcd_hi), vecs[i].exp_hi);
        end

        // Round-robin with all requests held, including re-serve of requester 0.
        vals       = '{7'd12, 7'd34, 7'd99};
        conv_delay = 10;
        req        = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr%0d", k), 100, a, e, h, l, lat);
            if (k == 3) req = 3'b000;
            check($sformatf("rr%0d_ack", k), a, rr_ack[k]);
            check($sformatf("rr%0d_hi", k),  h, rr_hi[k]);
            check($sformatf("rr%0d_lo", k),  l, rr_lo[k]);
            check($sformatf("rr%0d_err", k), e, 0);
        end
        @(negedge clk);
        check("rr_busy_after", int'(busy), 0);

        // Operand stability: requester changes its value during WAIT.
        din_bad    = 0;
        vals[0]    = 7'd5;
        req        = 3'b001;
        conv_delay = 10;
        repeat (7) @(negedge clk);
        vals[0] = 7'd88;
        check("stab_busy", int'(busy), 1);
        @(negedge clk);
        check("stab_din", int'(conv_din), 5);
        wait_ack("stab", 100, a, e, h, l, lat);
        req = 3'b000;
        check("stab_ack",      a,           1);
        check("stab_hi",       h,           0);
        check("stab_lo",       l,           5);
        check("stab_conv_val", int'(m_val), 5);
        check("stab_din_hold", din_bad,     0);
        @(negedge clk);

        // Reset during WAIT abandons the conversion; pending requester 2 served afterwards.
        vals[0]    = 7'd50;
        req        = 3'b001;
        conv_delay = 30;
        repeat (8) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy",       int'(busy),       0);
        check("mid_rst_conv_start", int'(conv_start), 0);
        check("mid_rst_conv_din",   int'(conv_din),   0);
        check("mid_rst_ack",        int'(ack),        0);
        check("mid_rst_bcd_lo",     int'(bcd_lo),     0);
        req        = 3'b100;
        vals[2]    = 7'd77;
        conv_delay = 10;
        repeat (2) @(negedge clk);
        check("mid_rst_ack_held", int'(ack), 0);
        rst = 1'b1;
        wait_ack("mid", 100, a, e, h, l, lat);
        req = 3'b000;
        check("mid_ack", a,   4);
        check("mid_hi",  h,   7);
        check("mid_lo",  l,   7);
        check("mid_err", e,   0);
        check("mid_lat", lat, 12);
        @(negedge clk);

        // Randomized traffic against the round-robin reference model.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ptr = 0;
        for (int it = 0; it < 40; it++) begin
            pend_m = int'($urandom_range(1, 7));
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 3) == 0) vals[j] = 7'($urandom_range(100, 127));
                else                           vals[j] = 7'($urandom_range(0, 99));
            end
            dly        = int'($urandom_range(4, 38));
            conv_delay = dly;
            req        = 3'(pend_m);
            while (pend_m != 0) begin
                exp_idx = ptr;
                for (int k = 2; k >= 0; k--) begin
                    if (pend_m[(ptr + k) % 3]) exp_idx = (ptr + k) % 3;
                end
                ref_result(int'(vals[exp_idx]), dly, rh, rl, re);
                wait_ack($sformatf("rnd%0d", it), 200, a, e, h, l, lat);
                req[exp_idx] = 1'b0;
                check($sformatf("rnd%0d_ack", it), a, 1 << exp_idx);
                check($sformatf("rnd%0d_hi", it),  h, rh);
                check($sformatf("rnd%0d_lo", it),  l, rl);
                check($sformatf("rnd%0d_err", it), e, re);
                pend_m[exp_idx] = 1'b0;
                ptr = (exp_idx + 1) % 3;
            end
            req = 3'b000;
            @(negedge clk);
        end

        check("protocol_monitor", mon_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
